// File: rtl/d_cache_2way_wt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// d_cache_2way_wt: 2-way set-associative write-through/no-allocate data cache
// with LRU replacement and optional kseg1 uncached bypass.   Rev 1.0
// ----------------------------------------------------------------------------
module d_cache_2way_wt #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter bit UNCACHED_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int WW         = OFFSET_WIDTH - 2;
  localparam int LINE_WORDS = 1 << WW;
  localparam int TAG_W      = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WMEM, S_UNC} state_e;

  state_e            state_q, state_d;
  logic [1:0]        valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [31:0]       data_q  [2][SETS][LINE_WORDS];
  logic [SETS-1:0]   lru_q;
  logic [WW-1:0]     cnt_q;
  logic              addr_rcv_q, ok_q, victim_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [1:0]        size_q;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_WIDTH-1:0] req_idx, idx_q;
  logic [WW-1:0]          req_word, word_q;
  logic                   req_unc, accept, hit, hit_way, busy, mem_done, last;
  logic [1:0]             hit_vec;
  logic [3:0]             wmask;

  assign req_tag  = cpu_data_addr[31 -: TAG_W];
  assign req_idx  = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word = cpu_data_addr[2 +: WW];
  assign req_unc  = UNCACHED_EN && (cpu_data_addr[31:29] == 3'b101);
  assign idx_q    = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign word_q   = addr_q[2 +: WW];

  always_comb begin
    hit_vec = 2'b00;
    for (int w = 0; w < 2; w++)
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag) && !req_unc;
  end
  assign hit     = |hit_vec;
  assign hit_way = hit_vec[1];

  // No acceptance in the refill-return cycle so two data_ok pulses never merge.
  assign accept   = (state_q == S_IDLE) && cpu_data_req && !ok_q && !rst;
  assign busy     = (state_q != S_IDLE);
  assign mem_done = busy && cache_data_data_ok && (addr_rcv_q || cache_data_addr_ok);
  assign last     = &cnt_q;

  always_comb begin
    wmask = 4'b0000;
    case (cpu_data_size)
      2'd0:    wmask = 4'b0001 << cpu_data_addr[1:0];
      2'd1:    wmask = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
      default: wmask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    cpu_data_addr_ok = accept;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    cache_data_req   = busy && !addr_rcv_q;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'd0;
    cache_data_addr  = '0;
    cache_data_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (ok_q) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = rdata_q;
        end else if (accept) begin
          if (cpu_data_wr) state_d = S_WMEM;
          else if (req_unc) state_d = S_UNC;
          else if (hit) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = data_q[hit_way][req_idx][req_word];
          end else state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        cache_data_size = 2'd2;
        cache_data_addr = {addr_q[31:OFFSET_WIDTH], cnt_q, 2'b00};
        if (mem_done && last) state_d = S_IDLE;
      end
      S_WMEM: begin
        cache_data_wr    = 1'b1;
        cache_data_size  = size_q;
        cache_data_addr  = addr_q;
        cache_data_wdata = wdata_q;
        if (mem_done) begin
          cpu_data_data_ok = 1'b1;
          state_d          = S_IDLE;
        end
      end
      S_UNC: begin
        cache_data_size = size_q;
        cache_data_addr = addr_q;
        if (mem_done) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = cache_data_rdata;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lru_q      <= '0;
      cnt_q      <= '0;
      addr_rcv_q <= 1'b0;
      ok_q       <= 1'b0;
      victim_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= 2'd0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
    end else begin
      state_q <= state_d;
      ok_q    <= 1'b0;
      if (mem_done) addr_rcv_q <= 1'b0;
      else if (cache_data_req && cache_data_addr_ok) addr_rcv_q <= 1'b1;
      if (accept) begin
        addr_q   <= cpu_data_addr;
        size_q   <= cpu_data_size;
        wdata_q  <= cpu_data_wdata;
        cnt_q    <= '0;
        victim_q <= !valid_q[req_idx][0] ? 1'b0 :
                    !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];
        if (hit) lru_q[req_idx] <= ~hit_way;
      end
      if (state_q == S_REFILL && mem_done) begin
        cnt_q <= cnt_q + WW'(1);
        if (cnt_q == word_q) rdata_q <= cache_data_rdata;
        if (last) begin
          valid_q[idx_q][victim_q] <= 1'b1;
          lru_q[idx_q]             <= ~victim_q;
          ok_q                     <= 1'b1;
        end
      end
    end
  end

  // Line storage carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (accept && cpu_data_wr && hit)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) data_q[hit_way][req_idx][req_word][8*b +: 8] <= cpu_data_wdata[8*b +: 8];
    if (state_q == S_REFILL && mem_done) begin
      data_q[victim_q][idx_q][cnt_q] <= cache_data_rdata;
      if (last) tag_q[victim_q][idx_q] <= addr_q[31 -: TAG_W];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_cache_2way_wt.sv
`default_nettype none
// tb_d_cache_2way_wt: directed vector table against a behavioural memory,
// plus slow-memory handshake and mid-refill reset sequences.
module tb_d_cache_2way_wt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_data_req = 1'b0, cpu_data_wr = 1'b0;
  logic [1:0]  cpu_data_size = 2'd0;
  logic [31:0] cpu_data_addr = '0, cpu_data_wdata = '0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata;
  logic [31:0] cache_data_rdata = '0;
  logic        cache_data_addr_ok = 1'b0, cache_data_data_ok = 1'b0;

  d_cache_2way_wt #(.INDEX_WIDTH(6), .OFFSET_WIDTH(4), .UNCACHED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr), .cache_data_size(cache_data_size),
    .cache_data_addr(cache_data_addr), .cache_data_wdata(cache_data_wdata),
    .cache_data_rdata(cache_data_rdata), .cache_data_addr_ok(cache_data_addr_ok),
    .cache_data_data_ok(cache_data_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rd; int exp_nmem; bit exp_hit;
  } vec_t;
  typedef struct { logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } mrec_t;

  int errs = 0, checks = 0;
  mrec_t mlog[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return w ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: addr_ok after adly waiting cycles, data_ok ddly cycles later.
  int adly = 0, ddly = 0, a_cnt = 0, d_cnt = 0, n_dok = 0;
  bit pend = 1'b0;
  mrec_t cur;
  always @(negedge clk) begin
    logic [3:0]  m;
    logic [31:0] w;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    if (rst) begin
      pend = 1'b0; a_cnt = 0;
    end else if (pend) begin
      if (d_cnt >= ddly) begin
        cache_data_data_ok = 1'b1;
        cache_data_rdata   = mem_rd(cur.addr);
        n_dok++;
        pend = 1'b0;
        if (cur.wr) begin
          m = (cur.size == 2'd0) ? (4'b0001 << cur.addr[1:0]) :
              (cur.size == 2'd1) ? (cur.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          w = mem_rd(cur.addr);
          for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
          mem[{cur.addr[31:2], 2'b00}] = w;
        end
      end else d_cnt++;
    end else if (cache_data_req) begin
      if (a_cnt >= adly) begin
        cache_data_addr_ok = 1'b1;
        cur = '{cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata};
        mlog.push_back(cur);
        pend = 1'b1; d_cnt = 0; a_cnt = 0;
      end else a_cnt++;
    end else a_cnt = 0;
  end

  bit mon_en = 1'b0;
  int mon_req_hi = 0, mon_req_viol = 0, mon_cpu_aok = 0;
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (cache_data_req) mon_req_hi++;
      if (cache_data_req && pend && !cache_data_addr_ok) mon_req_viol++;
      if (cpu_data_addr_ok) mon_cpu_aok++;
    end
  end

  task automatic cpu_op(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] rd,
                        output int acc_c, output int done_c, output bit to);
    int cyc;
    bit acc;
    acc = 1'b0; acc_c = -1; done_c = -1; to = 1'b1; rd = '0; cyc = 0;
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = sz;
    cpu_data_addr = a; cpu_data_wdata = wd;
    while (cyc < 300) begin
      #1;
      if (!acc && cpu_data_addr_ok) begin acc = 1'b1; acc_c = cyc; end
      if (cpu_data_data_ok) begin done_c = cyc; rd = cpu_data_rdata; to = 1'b0; break; end
      @(negedge clk);
      if (acc && !hold) begin
        cpu_data_req = 1'b0; cpu_data_addr = ~a; cpu_data_wdata = ~wd; cpu_data_wr = ~wr;
      end
      cyc++;
    end
    @(negedge clk);
    cpu_data_req = 1'b0;
  endtask

  vec_t vt[17];
  logic [31:0] rd;
  int acc_c, done_c;
  bit to;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    mem[32'h104] = 32'h1122_3344;
    //          wr    size  addr          wdata         exp_rd        nmem hit
    vt[0]  = '{1'b0, 2'd2, 32'h0000_0104, 32'h0,        32'h1122_3344, 4, 1'b0};
    vt[1]  = '{1'b0, 2'd2, 32'h0000_0104, 32'h0,        32'h1122_3344, 0, 1'b1};
    vt[2]  = '{1'b0, 2'd2, 32'h0000_0108, 32'h0,        32'h5A5A_0108, 0, 1'b1};
    vt[3]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,        32'h5A5A_0010, 4, 1'b0};
    vt[4]  = '{1'b0, 2'd2, 32'h0000_0410, 32'h0,        32'h5A5A_0410, 4, 1'b0};
    vt[5]  = '{1'b0, 2'd2, 32'h0000_0010, 32'h0,        32'h5A5A_0010, 0, 1'b1};
    vt[6]  = '{1'b0, 2'd2, 32'h0000_0810, 32'h0,        32'h5A5A_0810, 4, 1'b0};
    vt[7]  = '{1'b0, 2'd2, 32'h0000_0014, 32'h0,        32'h5A5A_0014, 0, 1'b1};
    vt[8]  = '{1'b0, 2'd2, 32'h0000_0410, 32'h0,        32'h5A5A_0410, 4, 1'b0};
    vt[9]  = '{1'b1, 2'd0, 32'h0000_0105, 32'hABAB_ABAB, 32'h0,        1, 1'b0};
    vt[10] = '{1'b0, 2'd2, 32'h0000_0104, 32'h0,        32'h1122_AB44, 0, 1'b1};
    vt[11] = '{1'b1, 2'd2, 32'hA000_0020, 32'h1234_5678, 32'h0,        1, 1'b0};
    vt[12] = '{1'b0, 2'd2, 32'hA000_0010, 32'h0,        32'hFA5A_0010, 1, 1'b0};
    vt[13] = '{1'b0, 2'd2, 32'hA000_0010, 32'h0,        32'hFA5A_0010, 1, 1'b0};
    vt[14] = '{1'b0, 2'd2, 32'hA000_0020, 32'h0,        32'h1234_5678, 1, 1'b0};
    vt[15] = '{1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_0000, 32'h0,        1, 1'b0};
    vt[16] = '{1'b0, 2'd2, 32'h0000_2000, 32'h0,        32'hBEEF_2000, 4, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check("reset ctl {req,wr,size,aok,dok}",
          {26'b0, cache_data_req, cache_data_wr, cache_data_size, cpu_data_addr_ok, cpu_data_data_ok}, 32'h0);
    check("reset cache_data_addr", cache_data_addr, 32'h0);
    check("reset cpu_data_rdata", cpu_data_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      mlog.delete();
      cpu_op(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, 1'b0, rd, acc_c, done_c, to);
      check($sformatf("v%0d timeout", i), {31'b0, to}, 32'h0);
      if (!vt[i].wr) check($sformatf("v%0d rdata", i), rd, vt[i].exp_rd);
      check($sformatf("v%0d mem accesses", i), 32'(mlog.size()), 32'(vt[i].exp_nmem));
      check($sformatf("v%0d same-cycle hit", i), {31'b0, (acc_c == 0 && done_c == 0)}, {31'b0, vt[i].exp_hit});
      if (mlog.size() == vt[i].exp_nmem && vt[i].exp_nmem == 4) begin
        for (int j = 0; j < 4; j++) begin
          check($sformatf("v%0d refill addr %0d", i, j), mlog[j].addr, (vt[i].addr & ~32'hF) + 32'(4 * j));
          check($sformatf("v%0d refill wr/size %0d", i, j), {29'b0, mlog[j].wr, mlog[j].size}, 32'h2);
        end
      end else if (mlog.size() == vt[i].exp_nmem && vt[i].exp_nmem == 1) begin
        check($sformatf("v%0d single addr", i), mlog[0].addr, vt[i].addr);
        check($sformatf("v%0d single wr/size", i), {29'b0, mlog[0].wr, mlog[0].size}, {29'b0, vt[i].wr, vt[i].size});
        if (vt[i].wr) check($sformatf("v%0d single wdata", i), mlog[0].wdata, vt[i].wdata);
      end
    end

    // Slow memory: addr_ok after 5 waiting cycles, data_ok 3 cycles later.
    adly = 5; ddly = 3;
    mlog.delete();
    mon_req_hi = 0; mon_req_viol = 0; mon_cpu_aok = 0; mon_en = 1'b1;
    cpu_op(1'b0, 2'd2, 32'h0000_0300, 32'h0, 1'b1, rd, acc_c, done_c, to);
    mon_en = 1'b0;
    check("slow timeout", {31'b0, to}, 32'h0);
    check("slow rdata", rd, 32'h5A5A_0300);
    check("slow mem accesses", 32'(mlog.size()), 32'd4);
    check("slow req-high cycles", 32'(mon_req_hi), 32'd24);
    check("slow req while outstanding", 32'(mon_req_viol), 32'd0);
    check("slow cpu addr_ok cycles", 32'(mon_cpu_aok), 32'd1);
    adly = 0; ddly = 0;

    // Reset asserted after two of four refill words.
    mlog.delete();
    n_dok = 0;
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'd2; cpu_data_addr = 32'h0000_0500;
    @(negedge clk);
    cpu_data_req = 1'b0;
    begin
      int k;
      k = 0;
      while (n_dok < 2 && k < 100) begin @(negedge clk); #1; k++; end
    end
    check("rst-mid words before reset", 32'(n_dok), 32'd2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst-mid ctl {req,wr,size,aok,dok}",
          {26'b0, cache_data_req, cache_data_wr, cache_data_size, cpu_data_addr_ok, cpu_data_data_ok}, 32'h0);
    check("rst-mid cache_data_addr", cache_data_addr, 32'h0);
    check("rst-mid cache_data_wdata", cache_data_wdata, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    mlog.delete();
    cpu_op(1'b0, 2'd2, 32'h0000_0500, 32'h0, 1'b0, rd, acc_c, done_c, to);
    check("rst-mid reread timeout", {31'b0, to}, 32'h0);
    check("rst-mid reread rdata", rd, 32'h5A5A_0500);
    check("rst-mid reread mem accesses", 32'(mlog.size()), 32'd4);
    if (mlog.size() == 4)
      for (int j = 0; j < 4; j++)
        check($sformatf("rst-mid refill addr %0d", j), mlog[j].addr, 32'h500 + 32'(4 * j));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
